// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
//   Shared constants and helpers for the scoreboarded register file.
//   DATA_W_DEF / ADDR_W_DEF : default register width and index width
//   ZERO_IDX                : index of the hardwired-zero register
//   MAX_ADDR_W / MAX_DEPTH  : largest index width the popcount helper covers
//   popcount()              : number of set bits in a busy vector
// ---------------------------------------------------------------------------
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int ZERO_IDX   = 0;

    // Busy vectors narrower than MAX_DEPTH are zero-extended by the caller.
    localparam int MAX_ADDR_W = 8;
    localparam int MAX_DEPTH  = 1 << MAX_ADDR_W;

    function automatic int unsigned popcount(input logic [MAX_DEPTH-1:0] vec);
        int unsigned n;
        n = 0;
        for (int i = 0; i < MAX_DEPTH; i++) begin
            if (vec[i]) n++;
        end
        return n;
    endfunction

endpackage

// File: rtl/regfile_busy_sb.sv
// ---------------------------------------------------------------------------
// regfile_busy_sb
//   Pending-write scoreboard: one busy bit per architectural register, set
//   when a producer issues and cleared when it writes back, plus a
//   registered count of busy registers.
//   clk, resetN                 : clock, asynchronous active-low reset
//   writeEnable, writeRegister  : writeback clears busy[writeRegister]
//   flush                       : clears every busy bit
//   issueValid, issueRegister   : sets busy[issueRegister]
//   busy                        : current busy vector
//   pendingCount                : popcount of busy, ADDR_W+1 bits wide
// ---------------------------------------------------------------------------
module regfile_busy_sb
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                     clk,
    input  logic                     resetN,
    input  logic                     writeEnable,
    input  logic [ADDR_W-1:0]        writeRegister,
    input  logic                     flush,
    input  logic                     issueValid,
    input  logic [ADDR_W-1:0]        issueRegister,
    output logic [(1<<ADDR_W)-1:0]   busy,
    output logic [ADDR_W:0]          pendingCount
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = ADDR_W + 1;

    logic [DEPTH-1:0]     busy_q;
    logic [DEPTH-1:0]     busy_d;
    logic [CNT_W-1:0]     pending_count_q;
    logic [CNT_W-1:0]     pending_count_d;
    logic [MAX_DEPTH-1:0] busy_ext;
    logic                 issue_ok;

    assign issue_ok = issueValid &&
                      !(ZERO_REG && (issueRegister == ADDR_W'(ZERO_IDX)));

    // NOTE: every variable gets a default at the top of an always_comb so no
    // path leaves it unassigned; skipping that infers a latch.
    always_comb begin
        busy_d   = busy_q;
        busy_ext = '0;
        // Order matters: an issue in the same cycle as its own writeback or
        // a flush belongs to a newer producer, so it is applied last.
        if (writeEnable) busy_d[writeRegister] = 1'b0;
        if (flush)       busy_d = '0;
        if (issue_ok)    busy_d[issueRegister] = 1'b1;
        busy_ext[DEPTH-1:0] = busy_d;
        pending_count_d     = CNT_W'(popcount(busy_ext));
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values; blocking here would create order races.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            busy_q          <= '0;
            pending_count_q <= '0;
        end else begin
            busy_q          <= busy_d;
            pending_count_q <= pending_count_d;
        end
    end

    assign busy         = busy_q;
    assign pendingCount = pending_count_q;

endmodule

// File: rtl/regfile_sb.sv
// ---------------------------------------------------------------------------
// regfile_sb
//   Multi-read-port register file with same-cycle write bypass, optional
//   hardwired-zero register and an integrated pending-write scoreboard.
//   clk, resetN                          : clock, async active-low reset
//   writeEnable/writeRegister/writeData  : writeback port
//   readRegister  [NUM_READ*ADDR_W]      : read addresses, port i in slice i
//   readData      [NUM_READ*DATA_W]      : combinational read data
//   readBusy      [NUM_READ]             : operand still pending
//   issueValid/issueRegister             : destination of issued instruction
//   flush                                : clears all busy bits
//   pendingCount  [ADDR_W+1]             : registered count of busy registers
// ---------------------------------------------------------------------------
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_READ = 2,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                       clk,
    input  logic                       resetN,
    input  logic                       writeEnable,
    input  logic [ADDR_W-1:0]          writeRegister,
    input  logic [DATA_W-1:0]          writeData,
    input  logic [NUM_READ*ADDR_W-1:0] readRegister,
    output logic [NUM_READ*DATA_W-1:0] readData,
    output logic [NUM_READ-1:0]        readBusy,
    input  logic                       issueValid,
    input  logic [ADDR_W-1:0]          issueRegister,
    input  logic                       flush,
    output logic [ADDR_W:0]            pendingCount
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic              write_ok;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_hit;

    regfile_busy_sb #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_busy (
        .clk           (clk),
        .resetN        (resetN),
        .writeEnable   (writeEnable),
        .writeRegister (writeRegister),
        .flush         (flush),
        .issueValid    (issueValid),
        .issueRegister (issueRegister),
        .busy          (busy),
        .pendingCount  (pendingCount)
    );

    assign write_ok = writeEnable &&
                      !(ZERO_REG && (writeRegister == ADDR_W'(ZERO_IDX)));

    always_comb begin
        mem_d = mem_q;
        if (write_ok) mem_d[writeRegister] = writeData;
    end

    // NOTE: the array is reset entry by entry because the core relies on
    // every register reading 0 after reset; this costs a reset net per flop
    // and rules out mapping the array onto a RAM macro.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    // Read ports. Outputs are forced to 0 while reset is held so the bypass
    // path cannot leak writeData before the first edge.
    always_comb begin
        readData = '0;
        readBusy = '0;
        rd_addr  = '0;
        rd_hit   = 1'b0;
        for (int p = 0; p < NUM_READ; p++) begin
            rd_addr = readRegister[p*ADDR_W +: ADDR_W];
            rd_hit  = writeEnable && (writeRegister == rd_addr);
            if (!resetN) begin
                readData[p*DATA_W +: DATA_W] = '0;
                readBusy[p]                  = 1'b0;
            end else if (ZERO_REG && (rd_addr == ADDR_W'(ZERO_IDX))) begin
                readData[p*DATA_W +: DATA_W] = '0;
                readBusy[p]                  = 1'b0;
            end else if (rd_hit) begin
                // Bypassed operands are available now, so never busy.
                readData[p*DATA_W +: DATA_W] = writeData;
                readBusy[p]                  = 1'b0;
            end else begin
                readData[p*DATA_W +: DATA_W] = mem_q[rd_addr];
                readBusy[p]                  = busy[rd_addr];
            end
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// ---------------------------------------------------------------------------
// tb_regfile_sb
//   Self-checking bench for regfile_sb (32x32, two read ports, zero reg).
//   Inputs change just after the falling edge, outputs are sampled 1 ns
//   later; a behavioural model of the architectural state (register values
//   and the set of registers with a producer in flight) is advanced at each
//   rising edge.
// ---------------------------------------------------------------------------
module tb_regfile_sb;

    logic        clk;
    logic        resetN;
    logic        writeEnable;
    logic [4:0]  writeRegister;
    logic [31:0] writeData;
    logic [9:0]  readRegister;
    logic [63:0] readData;
    logic [1:0]  readBusy;
    logic        issueValid;
    logic [4:0]  issueRegister;
    logic        flush;
    logic [5:0]  pendingCount;

    int total = 0;
    int bad   = 0;

    // Reference model
    logic [31:0] m_mem [32];
    bit          m_busy [32];

    regfile_sb #(
        .DATA_W   (32),
        .ADDR_W   (5),
        .NUM_READ (2),
        .ZERO_REG (1'b1)
    ) dut (
        .clk           (clk),
        .resetN        (resetN),
        .writeEnable   (writeEnable),
        .writeRegister (writeRegister),
        .writeData     (writeData),
        .readRegister  (readRegister),
        .readData      (readData),
        .readBusy      (readBusy),
        .issueValid    (issueValid),
        .issueRegister (issueRegister),
        .flush         (flush),
        .pendingCount  (pendingCount)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- model ----------------
    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < 32; i++) if (m_busy[i]) n++;
        return n;
    endfunction

    function automatic logic [31:0] exp_data(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (writeEnable && writeRegister == a) return writeData;
        return m_mem[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        if (writeEnable && writeRegister == a) return 1'b0;
        return m_busy[a];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            m_mem[i]  = 32'd0;
            m_busy[i] = 1'b0;
        end
    endtask

    // Architectural effect of one clock edge: register written, the written
    // producer retires, a flush kills everything in flight, and a register
    // issued this cycle is awaited regardless.
    task automatic model_edge();
        if (writeEnable && writeRegister != 5'd0) m_mem[writeRegister] = writeData;
        if (writeEnable) m_busy[writeRegister] = 1'b0;
        if (flush) for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        if (issueValid && issueRegister != 5'd0) m_busy[issueRegister] = 1'b1;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        writeEnable   = 1'b0;
        writeRegister = 5'd0;
        writeData     = 32'd0;
        issueValid    = 1'b0;
        issueRegister = 5'd0;
        flush         = 1'b0;
    endtask

    task automatic set_reads(input logic [4:0] r0, input logic [4:0] r1);
        readRegister = {r1, r0};
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        resetN = 1'b0;
        idle();
        set_reads(5'd0, 5'd0);
        model_clear();
        for (int a = 0; a < 32; a++) begin
            @(negedge clk);
            // Active write/issue while held must not leak to the outputs.
            writeEnable   = 1'b1;
            writeRegister = 5'(a);
            writeData     = $urandom() | 32'h1;
            issueValid    = 1'b1;
            issueRegister = 5'(a);
            set_reads(5'(a), 5'(a));
            #1;
            total++;
            if (readData !== 64'd0) begin
                bad++;
                $display("FAIL reset_data addr=%0d got=%h want=0", a, readData);
            end
            total++;
            if (readBusy !== 2'b00) begin
                bad++;
                $display("FAIL reset_busy addr=%0d got=%b want=00", a, readBusy);
            end
            total++;
            if (pendingCount !== 6'd0) begin
                bad++;
                $display("FAIL reset_count addr=%0d got=%0d want=0", a, pendingCount);
            end
        end
        @(negedge clk);
        idle();
        #2;
        resetN = 1'b1;
        @(negedge clk);
        #1;
    endtask

    task automatic test_write_bypass();
        writeEnable = 1'b1; writeRegister = 5'd5; writeData = 32'hDEADBEEF;
        set_reads(5'd5, 5'd0);
        #1;
        total++;
        if (readData[31:0] !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL bypass_x5 got=%h want=deadbeef", readData[31:0]);
        end
        tick();
        idle();
        #1;
        total++;
        if (readData[31:0] !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL array_x5 got=%h want=deadbeef", readData[31:0]);
        end
        writeEnable = 1'b1; writeRegister = 5'd0; writeData = 32'h1234;
        set_reads(5'd0, 5'd5);
        #1;
        total++;
        if (readData[31:0] !== 32'd0) begin
            bad++;
            $display("FAIL bypass_x0 got=%h want=0", readData[31:0]);
        end
        tick();
        idle();
        #1;
        total++;
        if (readData[31:0] !== 32'd0) begin
            bad++;
            $display("FAIL array_x0 got=%h want=0", readData[31:0]);
        end
    endtask

    task automatic test_issue_writeback();
        issueValid = 1'b1; issueRegister = 5'd7;
        set_reads(5'd0, 5'd7);
        #1;
        total++;
        if (readBusy[1] !== 1'b0) begin
            bad++;
            $display("FAIL issue_same_cycle got=%b want=0", readBusy[1]);
        end
        tick();
        idle();
        #1;
        total++;
        if (readBusy[1] !== 1'b1) begin
            bad++;
            $display("FAIL busy_x7 got=%b want=1", readBusy[1]);
        end
        total++;
        if (pendingCount !== 6'd1) begin
            bad++;
            $display("FAIL count_x7 got=%0d want=1", pendingCount);
        end
        writeEnable = 1'b1; writeRegister = 5'd7; writeData = 32'h55;
        #1;
        total++;
        if (readBusy[1] !== 1'b0 || readData[63:32] !== 32'h55) begin
            bad++;
            $display("FAIL wb_x7 busy=%b data=%h want busy=0 data=55", readBusy[1], readData[63:32]);
        end
        tick();
        idle();
        #1;
        total++;
        if (pendingCount !== 6'd0) begin
            bad++;
            $display("FAIL count_after_wb got=%0d want=0", pendingCount);
        end
    endtask

    task automatic test_issue_wb_same();
        issueValid = 1'b1; issueRegister = 5'd9;
        tick();
        idle();
        issueValid = 1'b1; issueRegister = 5'd9;
        writeEnable = 1'b1; writeRegister = 5'd9; writeData = 32'h77;
        tick();
        idle();
        set_reads(5'd9, 5'd0);
        #1;
        total++;
        if (readBusy[0] !== 1'b1) begin
            bad++;
            $display("FAIL same_busy_x9 got=%b want=1", readBusy[0]);
        end
        total++;
        if (pendingCount !== 6'd1) begin
            bad++;
            $display("FAIL same_count_x9 got=%0d want=1", pendingCount);
        end
        total++;
        if (readData[31:0] !== 32'h77) begin
            bad++;
            $display("FAIL same_data_x9 got=%h want=77", readData[31:0]);
        end
        writeEnable = 1'b1; writeRegister = 5'd9; writeData = 32'h78;
        tick();
        idle();
        #1;
        total++;
        if (pendingCount !== 6'd0) begin
            bad++;
            $display("FAIL same_clear_x9 got=%0d want=0", pendingCount);
        end
    endtask

    task automatic test_fill_flush();
        for (int r = 1; r < 32; r++) begin
            issueValid = 1'b1; issueRegister = 5'(r);
            tick();
            total++;
            if (pendingCount !== 6'(r)) begin
                bad++;
                $display("FAIL fill_count r=%0d got=%0d want=%0d", r, pendingCount, r);
            end
        end
        issueValid = 1'b1; issueRegister = 5'd2; flush = 1'b1;
        tick();
        idle();
        #1;
        total++;
        if (pendingCount !== 6'd1) begin
            bad++;
            $display("FAIL flush_count got=%0d want=1", pendingCount);
        end
        for (int a = 0; a < 32; a++) begin
            @(negedge clk);
            set_reads(5'(a), 5'(a));
            #1;
            total++;
            if (readBusy !== ((a == 2) ? 2'b11 : 2'b00)) begin
                bad++;
                $display("FAIL flush_busy addr=%0d got=%b", a, readBusy);
            end
        end
        writeEnable = 1'b1; writeRegister = 5'd2; writeData = 32'h2;
        tick();
        idle();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            writeEnable   = ($urandom_range(0, 1) == 1);
            writeRegister = 5'($urandom_range(0, 31));
            writeData     = $urandom();
            issueValid    = ($urandom_range(0, 2) != 0);
            issueRegister = 5'($urandom_range(0, 31));
            flush         = ($urandom_range(0, 19) == 0);
            set_reads(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            if ($urandom_range(0, 3) == 0) readRegister[4:0] = writeRegister;
            #1;
            for (int p = 0; p < 2; p++) begin
                logic [4:0] a;
                a = readRegister[p*5 +: 5];
                total++;
                if (readData[p*32 +: 32] !== exp_data(a)) begin
                    bad++;
                    $display("FAIL rand_data n=%0d port=%0d addr=%0d got=%h want=%h",
                             n, p, a, readData[p*32 +: 32], exp_data(a));
                end
                total++;
                if (readBusy[p] !== exp_busy(a)) begin
                    bad++;
                    $display("FAIL rand_busy n=%0d port=%0d addr=%0d got=%b want=%b",
                             n, p, a, readBusy[p], exp_busy(a));
                end
            end
            tick();
            total++;
            if (pendingCount !== 6'(m_count())) begin
                bad++;
                $display("FAIL rand_count n=%0d got=%0d want=%0d", n, pendingCount, m_count());
            end
        end
        idle();
    endtask

    task automatic test_async_reset();
        flush = 1'b1;
        tick();
        idle();
        writeEnable = 1'b1; writeRegister = 5'd3; writeData = 32'hA5A50003;
        tick();
        idle();
        for (int r = 10; r < 13; r++) begin
            issueValid = 1'b1; issueRegister = 5'(r);
            tick();
        end
        idle();
        set_reads(5'd10, 5'd3);
        #1;
        total++;
        if (readBusy !== 2'b01 || readData[63:32] !== 32'hA5A50003 || pendingCount !== 6'd3) begin
            bad++;
            $display("FAIL pre_reset busy=%b data=%h count=%0d want busy=01 data=a5a50003 count=3",
                     readBusy, readData[63:32], pendingCount);
        end
        resetN = 1'b0;
        model_clear();
        #1;
        total++;
        if (readData !== 64'd0) begin
            bad++;
            $display("FAIL async_data got=%h want=0", readData);
        end
        total++;
        if (readBusy !== 2'b00) begin
            bad++;
            $display("FAIL async_busy got=%b want=00", readBusy);
        end
        total++;
        if (pendingCount !== 6'd0) begin
            bad++;
            $display("FAIL async_count got=%0d want=0", pendingCount);
        end
        @(negedge clk);
        resetN = 1'b1;
        set_reads(5'd3, 5'd10);
        #1;
        total++;
        if (readData !== 64'd0 || readBusy !== 2'b00) begin
            bad++;
            $display("FAIL post_reset data=%h busy=%b want 0", readData, readBusy);
        end
    endtask

    initial begin
        test_reset();
        test_write_bypass();
        test_issue_writeback();
        test_issue_wb_same();
        test_fill_flush();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
